// File: rtl/pcs_receive_ordered_set.sv
// rtl/pcs_receive_ordered_set.sv - PCS receive ordered-set delineation to GMII RXD/RX_DV/RX_ER
// Registered outputs: the response to a code-group appears on the following cycle.
module pcs_receive_ordered_set #(
    parameter int CNT_W = 16
) (
    input  logic             CLK,
    input  logic             RESET,
    input  logic             SYNC_STATUS,
    input  logic             RX_EVEN,
    input  logic [7:0]       RX_CG,
    input  logic             RX_CG_K,
    input  logic             RX_CG_INVALID,
    output logic [7:0]       RXD,
    output logic             RX_DV,
    output logic             RX_ER,
    output logic             receiving,
    output logic [CNT_W-1:0] rx_frame_count,
    output logic [CNT_W-1:0] rx_err_count
);

    typedef enum logic [3:0] {
        ST_LINK_FAILED,
        ST_WAIT_FOR_K,
        ST_RX_K,
        ST_IDLE_D,
        ST_START_OF_PACKET,
        ST_RECEIVE,
        ST_DATA_ERROR,
        ST_TRI,
        ST_TRR,
        ST_EARLY_END,
        ST_FALSE_CARRIER
    } state_t;

    state_t           state_q, state_d;
    logic [7:0]       rxd_q, rxd_d;
    logic             dv_q, dv_d;
    logic             er_q, er_d;
    logic             rcv_q, rcv_d;
    logic             errored_q, errored_d;
    logic             early_bc_q, early_bc_d;
    logic [CNT_W-1:0] frame_cnt_q, frame_cnt_d;
    logic [CNT_W-1:0] err_cnt_q, err_cnt_d;
    logic             frame_inc, err_inc;

    logic cg_ok, cg_data, cg_comma, cg_sop, cg_term, cg_ext, cg_idle_d;

    assign cg_ok     = !RX_CG_INVALID;
    assign cg_data   = cg_ok && !RX_CG_K;
    assign cg_comma  = cg_ok && RX_CG_K && (RX_CG == 8'hBC);
    assign cg_sop    = cg_ok && RX_CG_K && (RX_CG == 8'hFB);
    assign cg_term   = cg_ok && RX_CG_K && (RX_CG == 8'hFD);
    assign cg_ext    = cg_ok && RX_CG_K && (RX_CG == 8'hF7);
    assign cg_idle_d = cg_data && ((RX_CG == 8'hC5) || (RX_CG == 8'h50));

    always_comb begin
        state_d    = state_q;
        rxd_d      = 8'h00;
        dv_d       = 1'b0;
        er_d       = 1'b0;
        rcv_d      = 1'b0;
        errored_d  = errored_q;
        early_bc_d = early_bc_q;
        frame_inc  = 1'b0;
        err_inc    = 1'b0;

        case (state_q)
            ST_LINK_FAILED: begin
                state_d = ST_WAIT_FOR_K;
            end
            ST_WAIT_FOR_K: begin
                if (cg_comma && RX_EVEN) state_d = ST_RX_K;
            end
            ST_RX_K: begin
                state_d = cg_idle_d ? ST_IDLE_D : ST_WAIT_FOR_K;
            end
            ST_IDLE_D: begin
                if (cg_comma && RX_EVEN) begin
                    state_d = ST_RX_K;
                end else if (cg_sop && RX_EVEN) begin
                    state_d   = ST_START_OF_PACKET;
                    rxd_d     = 8'h55;
                    dv_d      = 1'b1;
                    rcv_d     = 1'b1;
                    errored_d = 1'b0;
                end else begin
                    state_d = ST_FALSE_CARRIER;
                    rxd_d   = 8'h0E;
                    er_d    = 1'b1;
                    err_inc = 1'b1;
                end
            end
            ST_START_OF_PACKET, ST_RECEIVE, ST_DATA_ERROR: begin
                if (cg_term) begin
                    state_d = ST_TRI;
                    rcv_d   = 1'b1;
                end else if (cg_comma) begin
                    state_d    = ST_EARLY_END;
                    er_d       = 1'b1;
                    err_inc    = 1'b1;
                    early_bc_d = 1'b1;
                end else if (cg_data) begin
                    state_d = ST_RECEIVE;
                    rxd_d   = RX_CG;
                    dv_d    = 1'b1;
                    rcv_d   = 1'b1;
                end else begin
                    // /V/, invalid code-groups and stray K characters all poison the frame
                    state_d   = ST_DATA_ERROR;
                    rxd_d     = RX_CG;
                    dv_d      = 1'b1;
                    er_d      = 1'b1;
                    rcv_d     = 1'b1;
                    errored_d = 1'b1;
                end
            end
            ST_TRI: begin
                if (cg_ext) begin
                    state_d   = ST_TRR;
                    frame_inc = !errored_q;
                    err_inc   = errored_q;
                end else begin
                    state_d    = ST_EARLY_END;
                    er_d       = 1'b1;
                    err_inc    = 1'b1;
                    early_bc_d = cg_comma;
                end
            end
            ST_TRR: begin
                if (cg_ext)                   state_d = ST_TRR;
                else if (cg_comma && RX_EVEN) state_d = ST_RX_K;
                else                          state_d = ST_WAIT_FOR_K;
            end
            ST_EARLY_END: begin
                // When a comma ended the frame, this code-group is judged as the one following it
                if (early_bc_q)                  state_d = cg_idle_d ? ST_IDLE_D : ST_WAIT_FOR_K;
                else if (cg_comma && RX_EVEN)    state_d = ST_RX_K;
                else                             state_d = ST_WAIT_FOR_K;
            end
            ST_FALSE_CARRIER: begin
                if (cg_comma && RX_EVEN) begin
                    state_d = ST_RX_K;
                end else begin
                    rxd_d = 8'h0E;
                    er_d  = 1'b1;
                end
            end
            default: begin
                state_d = ST_LINK_FAILED;
            end
        endcase

        if (!SYNC_STATUS) begin
            state_d   = ST_LINK_FAILED;
            rxd_d     = 8'h00;
            dv_d      = 1'b0;
            er_d      = rcv_q;
            rcv_d     = 1'b0;
            errored_d = 1'b0;
            frame_inc = 1'b0;
            err_inc   = rcv_q;
        end

        frame_cnt_d = frame_cnt_q;
        if (frame_inc && (frame_cnt_q != {CNT_W{1'b1}})) frame_cnt_d = frame_cnt_q + CNT_W'(1);
        err_cnt_d = err_cnt_q;
        if (err_inc && (err_cnt_q != {CNT_W{1'b1}})) err_cnt_d = err_cnt_q + CNT_W'(1);
    end

    always_ff @(posedge CLK) begin
        if (RESET) begin
            state_q     <= ST_LINK_FAILED;
            rxd_q       <= 8'h00;
            dv_q        <= 1'b0;
            er_q        <= 1'b0;
            rcv_q       <= 1'b0;
            errored_q   <= 1'b0;
            early_bc_q  <= 1'b0;
            frame_cnt_q <= '0;
            err_cnt_q   <= '0;
        end else begin
            state_q     <= state_d;
            rxd_q       <= rxd_d;
            dv_q        <= dv_d;
            er_q        <= er_d;
            rcv_q       <= rcv_d;
            errored_q   <= errored_d;
            early_bc_q  <= early_bc_d;
            frame_cnt_q <= frame_cnt_d;
            err_cnt_q   <= err_cnt_d;
        end
    end

    assign RXD            = rxd_q;
    assign RX_DV          = dv_q;
    assign RX_ER          = er_q;
    assign receiving      = rcv_q;
    assign rx_frame_count = frame_cnt_q;
    assign rx_err_count   = err_cnt_q;

endmodule

// File: tb/tb_pcs_receive_ordered_set.sv
// tb/tb_pcs_receive_ordered_set.sv - scoreboard bench for pcs_receive_ordered_set
module tb_pcs_receive_ordered_set;

    localparam int CW = 4;

    logic          CLK = 1'b0;
    logic          RESET = 1'b1;
    logic          SYNC_STATUS = 1'b0;
    logic          RX_EVEN = 1'b0;
    logic [7:0]    RX_CG = 8'h00;
    logic          RX_CG_K = 1'b0;
    logic          RX_CG_INVALID = 1'b0;
    logic [7:0]    RXD;
    logic          RX_DV;
    logic          RX_ER;
    logic          receiving;
    logic [CW-1:0] rx_frame_count;
    logic [CW-1:0] rx_err_count;

    pcs_receive_ordered_set #(.CNT_W(CW)) dut (
        .CLK(CLK), .RESET(RESET), .SYNC_STATUS(SYNC_STATUS), .RX_EVEN(RX_EVEN),
        .RX_CG(RX_CG), .RX_CG_K(RX_CG_K), .RX_CG_INVALID(RX_CG_INVALID),
        .RXD(RXD), .RX_DV(RX_DV), .RX_ER(RX_ER), .receiving(receiving),
        .rx_frame_count(rx_frame_count), .rx_err_count(rx_err_count)
    );

    always #5 CLK = ~CLK;

    typedef struct {
        int            id;
        logic [7:0]    rxd;
        logic          dv;
        logic          er;
        logic          rcv;
        logic [CW-1:0] fc;
        logic [CW-1:0] ec;
    } exp_t;

    exp_t exp_q[$];
    int   total = 0;
    int   bad = 0;
    int   vec_id = 0;

    // Monitor: every cycle the DUT presents a registered response for the code-group pushed last
    always @(negedge CLK) begin
        if (exp_q.size() > 0) begin
            exp_t e;
            e = exp_q.pop_front();
            total = total + 1;
            if (RXD !== e.rxd || RX_DV !== e.dv || RX_ER !== e.er || receiving !== e.rcv ||
                rx_frame_count !== e.fc || rx_err_count !== e.ec) begin
                bad = bad + 1;
                $display("FAIL vec%0d: got rxd=%02h dv=%b er=%b rcv=%b fc=%0d ec=%0d want rxd=%02h dv=%b er=%b rcv=%b fc=%0d ec=%0d",
                         e.id, RXD, RX_DV, RX_ER, receiving, rx_frame_count, rx_err_count,
                         e.rxd, e.dv, e.er, e.rcv, e.fc, e.ec);
            end
        end
    end

    task automatic send(input logic rst, input logic sync, input logic even, input logic k,
                        input logic [7:0] cg, input logic inv,
                        input logic [7:0] e_rxd, input logic e_dv, input logic e_er,
                        input logic e_rcv, input int e_fc, input int e_ec);
        exp_t e;
        RESET = rst; SYNC_STATUS = sync; RX_EVEN = even;
        RX_CG_K = k; RX_CG = cg; RX_CG_INVALID = inv;
        @(posedge CLK);
        e.id = vec_id; e.rxd = e_rxd; e.dv = e_dv; e.er = e_er; e.rcv = e_rcv;
        e.fc = CW'(e_fc); e.ec = CW'(e_ec);
        exp_q.push_back(e);
        vec_id = vec_id + 1;
        @(negedge CLK);
    endtask

    // Synchronized, valid code-group shorthand
    task automatic cg1(input logic even, input logic k, input logic [7:0] cg,
                       input logic [7:0] e_rxd, input logic e_dv, input logic e_er,
                       input logic e_rcv, input int e_fc, input int e_ec);
        send(1'b0, 1'b1, even, k, cg, 1'b0, e_rxd, e_dv, e_er, e_rcv, e_fc, e_ec);
    endtask

    task automatic idle_pair(input int fc, input int ec);
        cg1(1'b1, 1'b1, 8'hBC, 8'h00, 1'b0, 1'b0, 1'b0, fc, ec);
        cg1(1'b0, 1'b0, 8'hC5, 8'h00, 1'b0, 1'b0, 1'b0, fc, ec);
    endtask

    // Reset, then bring the link to IDLE_D: first BC only leaves LINK_FAILED
    task automatic reset_and_sync();
        send(1'b1, 1'b0, 1'b0, 1'b0, 8'h00, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 0, 0);
        send(1'b1, 1'b0, 1'b0, 1'b0, 8'h00, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 0, 0);
        cg1(1'b1, 1'b1, 8'hBC, 8'h00, 1'b0, 1'b0, 1'b0, 0, 0);
        cg1(1'b0, 1'b0, 8'hC5, 8'h00, 1'b0, 1'b0, 1'b0, 0, 0);
        idle_pair(0, 0);
    endtask

    initial begin
        @(negedge CLK);

        // 1: reset and idle acquisition
        reset_and_sync();
        idle_pair(0, 0);
        idle_pair(0, 0);

        // 2: clean frame
        cg1(1'b1, 1'b1, 8'hFB, 8'h55, 1'b1, 1'b0, 1'b1, 0, 0);
        cg1(1'b0, 1'b0, 8'h01, 8'h01, 1'b1, 1'b0, 1'b1, 0, 0);
        cg1(1'b1, 1'b0, 8'h02, 8'h02, 1'b1, 1'b0, 1'b1, 0, 0);
        cg1(1'b0, 1'b0, 8'h03, 8'h03, 1'b1, 1'b0, 1'b1, 0, 0);
        cg1(1'b1, 1'b1, 8'hFD, 8'h00, 1'b0, 1'b0, 1'b1, 0, 0);
        cg1(1'b0, 1'b1, 8'hF7, 8'h00, 1'b0, 1'b0, 1'b0, 1, 0);
        idle_pair(1, 0);

        // 3: frame with /V/
        cg1(1'b1, 1'b1, 8'hFB, 8'h55, 1'b1, 1'b0, 1'b1, 1, 0);
        cg1(1'b0, 1'b0, 8'h11, 8'h11, 1'b1, 1'b0, 1'b1, 1, 0);
        cg1(1'b1, 1'b1, 8'hFE, 8'hFE, 1'b1, 1'b1, 1'b1, 1, 0);
        cg1(1'b0, 1'b0, 8'h22, 8'h22, 1'b1, 1'b0, 1'b1, 1, 0);
        cg1(1'b1, 1'b1, 8'hFD, 8'h00, 1'b0, 1'b0, 1'b1, 1, 0);
        cg1(1'b0, 1'b1, 8'hF7, 8'h00, 1'b0, 1'b0, 1'b0, 1, 1);
        idle_pair(1, 1);

        // 4: false carrier, held through an odd BC, released by even BC
        cg1(1'b1, 1'b0, 8'h3A, 8'h0E, 1'b0, 1'b1, 1'b0, 1, 2);
        cg1(1'b0, 1'b0, 8'hC5, 8'h0E, 1'b0, 1'b1, 1'b0, 1, 2);
        cg1(1'b0, 1'b1, 8'hBC, 8'h0E, 1'b0, 1'b1, 1'b0, 1, 2);
        idle_pair(1, 2);
        // /S/ in odd position is a false carrier
        cg1(1'b0, 1'b1, 8'hFB, 8'h0E, 1'b0, 1'b1, 1'b0, 1, 3);
        idle_pair(1, 3);

        // 5: sync loss mid-frame, then mid-frame reset
        cg1(1'b1, 1'b1, 8'hFB, 8'h55, 1'b1, 1'b0, 1'b1, 1, 3);
        cg1(1'b0, 1'b0, 8'h44, 8'h44, 1'b1, 1'b0, 1'b1, 1, 3);
        send(1'b0, 1'b0, 1'b1, 1'b0, 8'h45, 1'b0, 8'h00, 1'b0, 1'b1, 1'b0, 1, 4);
        send(1'b0, 1'b0, 1'b0, 1'b0, 8'h46, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 1, 4);
        cg1(1'b1, 1'b1, 8'hBC, 8'h00, 1'b0, 1'b0, 1'b0, 1, 4);
        cg1(1'b0, 1'b0, 8'hC5, 8'h00, 1'b0, 1'b0, 1'b0, 1, 4);
        idle_pair(1, 4);
        cg1(1'b1, 1'b1, 8'hFB, 8'h55, 1'b1, 1'b0, 1'b1, 1, 4);
        cg1(1'b0, 1'b0, 8'h66, 8'h66, 1'b1, 1'b0, 1'b1, 1, 4);
        send(1'b1, 1'b1, 1'b1, 1'b0, 8'h67, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 0, 0);

        // early end by comma, and errored frame ended by /T/ without /R/
        reset_and_sync();
        cg1(1'b1, 1'b1, 8'hFB, 8'h55, 1'b1, 1'b0, 1'b1, 0, 0);
        cg1(1'b0, 1'b0, 8'h77, 8'h77, 1'b1, 1'b0, 1'b1, 0, 0);
        cg1(1'b1, 1'b1, 8'hBC, 8'h00, 1'b0, 1'b1, 1'b0, 0, 1);
        cg1(1'b0, 1'b0, 8'hC5, 8'h00, 1'b0, 1'b0, 1'b0, 0, 1);
        cg1(1'b1, 1'b1, 8'hFB, 8'h55, 1'b1, 1'b0, 1'b1, 0, 1);
        send(1'b0, 1'b1, 1'b0, 1'b0, 8'h12, 1'b1, 8'h12, 1'b1, 1'b1, 1'b1, 0, 1);
        cg1(1'b1, 1'b0, 8'h34, 8'h34, 1'b1, 1'b0, 1'b1, 0, 1);
        cg1(1'b0, 1'b1, 8'hFD, 8'h00, 1'b0, 1'b0, 1'b1, 0, 1);
        cg1(1'b1, 1'b1, 8'hBC, 8'h00, 1'b0, 1'b1, 1'b0, 0, 2);
        cg1(1'b0, 1'b0, 8'hC5, 8'h00, 1'b0, 1'b0, 1'b0, 0, 2);

        // 6: frame counter saturation with 2^CW+2 good frames
        reset_and_sync();
        for (int i = 0; i < (1 << CW) + 2; i++) begin
            int pre;
            int post;
            pre  = (i < 15) ? i : 15;
            post = (i + 1 < 15) ? i + 1 : 15;
            cg1(1'b1, 1'b1, 8'hFB, 8'h55, 1'b1, 1'b0, 1'b1, pre, 0);
            cg1(1'b0, 1'b0, 8'hAA, 8'hAA, 1'b1, 1'b0, 1'b1, pre, 0);
            cg1(1'b1, 1'b1, 8'hFD, 8'h00, 1'b0, 1'b0, 1'b1, pre, 0);
            cg1(1'b0, 1'b1, 8'hF7, 8'h00, 1'b0, 1'b0, 1'b0, post, 0);
            idle_pair(post, 0);
        end

        @(negedge CLK);
        #1;
        if (exp_q.size() != 0) begin
            bad = bad + 1;
            $display("FAIL drain: got %0d pending want 0", exp_q.size());
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
